// File: rtl/keymgr_op_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keymgr_op_pkg : shared types for the key manager operation-control stage
// Revision      : 1.0
// ----------------------------------------------------------------------------
package keymgr_op_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WIP      = 2'd1,
        DONE_OK  = 2'd2,
        DONE_ERR = 2'd3
    } op_status_e;

    // Sparse codes so a single upset cannot land on another legal state.
    typedef enum logic [3:0] {
        StInit     = 4'b0101,
        StIdle     = 4'b1010,
        StWait     = 4'b0011,
        StDisabled = 4'b1100
    } op_state_e;

    typedef enum logic [1:0] {
        OpAdvance  = 2'd0,
        OpGenId    = 2'd1,
        OpGenSwOut = 2'd2,
        OpGenHwOut = 2'd3
    } kmac_op_e;

endpackage
`default_nettype wire

// File: rtl/keymgr_op_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keymgr_op_ctrl_if : KMAC request/response channel of the op-control stage
// Revision          : 1.0
// ----------------------------------------------------------------------------
interface keymgr_op_ctrl_if;
    import keymgr_op_pkg::*;

    logic     kmac_req_o;
    kmac_op_e kmac_op_o;
    logic     kmac_done_i;
    logic     kmac_err_i;

    modport master (output kmac_req_o, output kmac_op_o,
                    input  kmac_done_i, input kmac_err_i);
    modport slave  (input  kmac_req_o, input  kmac_op_o,
                    output kmac_done_i, output kmac_err_i);
endinterface
`default_nettype wire

// File: rtl/keymgr_op_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keymgr_op_timer : saturating wait counter, expired at TimeoutCycles-1
// Revision        : 1.0
// ----------------------------------------------------------------------------
module keymgr_op_timer #(
    parameter int unsigned TimeoutCycles = 256
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);
    localparam int unsigned CntW = $clog2(TimeoutCycles);

    logic [CntW-1:0] cnt;

    assign expired = (cnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CntW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/keymgr_op_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keymgr_op_ctrl : sequences one KMAC transaction per start, drives cfg-enable
// Revision       : 1.0
// ----------------------------------------------------------------------------
module keymgr_op_ctrl
    import keymgr_op_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 256
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic        en_i,
    input  wire logic        init_done_i,
    input  wire logic        start_i,
    input  wire logic [1:0]  op_i,
    keymgr_op_ctrl_if.master kmac,
    output logic             cfg_init_o,
    output logic             cfg_clr_o,
    output logic             cfg_set_o,
    output logic             busy_o,
    output logic [1:0]       status_o,
    output logic             err_timeout_o,
    output logic             err_kmac_o,
    output logic             err_disabled_o
);
    op_state_e  state;
    op_status_e status;
    kmac_op_e   op_latched;
    logic       in_flight;
    logic       cfg_init;
    logic       cfg_set;
    logic       err_timeout;
    logic       err_kmac;
    logic       err_disabled;
    logic       accept;
    logic       expired;

    // A start landing on an init/set pulse cycle is dropped so that the three
    // cfg pulses can never overlap.
    assign accept = (state == StIdle) && start_i && en_i && !cfg_init && !cfg_set;

    keymgr_op_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (accept),
        .en     ((state == StWait) && !kmac.kmac_done_i),
        .expired(expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= StInit;
            status       <= IDLE;
            op_latched   <= OpAdvance;
            in_flight    <= 1'b0;
            cfg_init     <= 1'b0;
            cfg_set      <= 1'b0;
            err_timeout  <= 1'b0;
            err_kmac     <= 1'b0;
            err_disabled <= 1'b0;
        end else begin
            cfg_init <= 1'b0;
            cfg_set  <= 1'b0;
            if (!en_i) begin
                state     <= StDisabled;
                in_flight <= 1'b0;
                if (state == StWait) begin
                    status       <= DONE_ERR;
                    err_disabled <= 1'b1;
                end
            end else begin
                case (state)
                    StInit: begin
                        if (init_done_i) begin
                            cfg_init <= 1'b1;
                            state    <= StIdle;
                        end
                    end
                    StIdle: begin
                        if (accept) begin
                            op_latched <= kmac_op_e'(op_i);
                            status     <= WIP;
                            in_flight  <= 1'b1;
                            state      <= StWait;
                        end
                    end
                    StWait: begin
                        // Done is checked first so a coincident timeout is not flagged.
                        if (kmac.kmac_done_i) begin
                            status    <= kmac.kmac_err_i ? DONE_ERR : DONE_OK;
                            err_kmac  <= err_kmac | kmac.kmac_err_i;
                            cfg_set   <= 1'b1;
                            in_flight <= 1'b0;
                            state     <= StIdle;
                        end else if (expired) begin
                            status      <= DONE_ERR;
                            err_timeout <= 1'b1;
                            cfg_set     <= 1'b1;
                            in_flight   <= 1'b0;
                            state       <= StIdle;
                        end
                    end
                    StDisabled: begin
                        in_flight <= 1'b0;
                    end
                    default: begin
                        in_flight <= 1'b0;
                        state     <= StDisabled;
                    end
                endcase
            end
        end
    end

    assign kmac.kmac_req_o = in_flight;
    assign kmac.kmac_op_o  = op_latched;
    assign busy_o          = in_flight;
    assign cfg_init_o      = cfg_init;
    assign cfg_clr_o       = accept;
    assign cfg_set_o       = cfg_set;
    assign status_o        = status;
    assign err_timeout_o   = err_timeout;
    assign err_kmac_o      = err_kmac;
    assign err_disabled_o  = err_disabled;
endmodule
`default_nettype wire

// File: tb/tb_keymgr_op_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_keymgr_op_ctrl : directed bench for keymgr_op_ctrl with TimeoutCycles=8
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_keymgr_op_ctrl;
    import keymgr_op_pkg::*;

    localparam int unsigned TO = 8;

    logic       clk_i       = 1'b0;
    logic       rst_ni      = 1'b0;
    logic       en_i        = 1'b0;
    logic       init_done_i = 1'b0;
    logic       start_i     = 1'b0;
    logic [1:0] op_i        = 2'd0;
    logic       cfg_init_o, cfg_clr_o, cfg_set_o, busy_o;
    logic [1:0] status_o;
    logic       err_timeout_o, err_kmac_o, err_disabled_o;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned n_init = 0;
    int unsigned n_clr  = 0;
    int unsigned n_set  = 0;
    int unsigned clr0, set0;

    keymgr_op_ctrl_if kmac_if();

    keymgr_op_ctrl #(.TimeoutCycles(TO)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .init_done_i   (init_done_i),
        .start_i       (start_i),
        .op_i          (op_i),
        .kmac          (kmac_if),
        .cfg_init_o    (cfg_init_o),
        .cfg_clr_o     (cfg_clr_o),
        .cfg_set_o     (cfg_set_o),
        .busy_o        (busy_o),
        .status_o      (status_o),
        .err_timeout_o (err_timeout_o),
        .err_kmac_o    (err_kmac_o),
        .err_disabled_o(err_disabled_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a start for one cycle; cfg_clr must answer in the same cycle.
    task automatic start_op(input logic [1:0] op);
        start_i = 1'b1;
        op_i    = op;
        #1;
        check("clr_same_cycle", 32'(cfg_clr_o), 32'd1);
        tick();
        start_i = 1'b0;
    endtask

    task automatic done_pulse(input logic err);
        kmac_if.kmac_done_i = 1'b1;
        kmac_if.kmac_err_i  = err;
        tick();
        kmac_if.kmac_done_i = 1'b0;
        kmac_if.kmac_err_i  = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("cfg_exclusive",
                  32'($countones({cfg_init_o, cfg_clr_o, cfg_set_o}) <= 1), 32'd1);
            n_init += 32'(cfg_init_o);
            n_clr  += 32'(cfg_clr_o);
            n_set  += 32'(cfg_set_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        kmac_if.kmac_done_i = 1'b0;
        kmac_if.kmac_err_i  = 1'b0;
        tick();
        tick();
        check("rst_status",  32'(status_o), 32'd0);
        check("rst_req",     32'(kmac_if.kmac_req_o), 32'd0);
        check("rst_op",      32'(kmac_if.kmac_op_o), 32'd0);
        check("rst_busy",    32'(busy_o), 32'd0);
        check("rst_init",    32'(cfg_init_o), 32'd0);
        check("rst_errs",    32'({err_timeout_o, err_kmac_o, err_disabled_o}), 32'd0);
        rst_ni = 1'b1;
        en_i   = 1'b1;

        // Start before init_done: no response at all.
        start_i = 1'b1;
        #1;
        check("pre_init_clr", 32'(cfg_clr_o), 32'd0);
        tick();
        start_i = 1'b0;
        check("pre_init_req",  32'(kmac_if.kmac_req_o), 32'd0);
        check("pre_init_init", 32'(cfg_init_o), 32'd0);

        init_done_i = 1'b1;
        tick();
        check("init_pulse", 32'(cfg_init_o), 32'd1);
        tick();
        check("init_low",   32'(cfg_init_o), 32'd0);
        check("init_count", n_init, 32'd1);

        // Successful op 2, done sampled with counter at 4.
        start_op(2'd2);
        check("t1_req",    32'(kmac_if.kmac_req_o), 32'd1);
        check("t1_op",     32'(kmac_if.kmac_op_o), 32'd2);
        check("t1_busy",   32'(busy_o), 32'd1);
        check("t1_wip",    32'(status_o), 32'd1);
        check("t1_clr_lo", 32'(cfg_clr_o), 32'd0);
        repeat (4) tick();
        done_pulse(1'b0);
        check("t1_set",    32'(cfg_set_o), 32'd1);
        check("t1_status", 32'(status_o), 32'd2);
        check("t1_busy_lo",32'(busy_o), 32'd0);
        check("t1_req_lo", 32'(kmac_if.kmac_req_o), 32'd0);
        tick();
        check("t1_set_lo", 32'(cfg_set_o), 32'd0);

        // KMAC error, then a clean op keeps the sticky flag.
        start_op(2'd1);
        repeat (2) tick();
        done_pulse(1'b1);
        check("t2_status",  32'(status_o), 32'd3);
        check("t2_errkmac", 32'(err_kmac_o), 32'd1);
        check("t2_errto",   32'(err_timeout_o), 32'd0);
        tick();
        start_op(2'd3);
        check("t3_op", 32'(kmac_if.kmac_op_o), 32'd3);
        done_pulse(1'b0);
        check("t3_status",  32'(status_o), 32'd2);
        check("t3_errkmac", 32'(err_kmac_o), 32'd1);
        tick();

        // Done on the last counter value wins over the timeout.
        start_op(2'd0);
        repeat (TO - 1) tick();
        check("t4_req_at7", 32'(kmac_if.kmac_req_o), 32'd1);
        done_pulse(1'b0);
        check("t4_status", 32'(status_o), 32'd2);
        check("t4_errto",  32'(err_timeout_o), 32'd0);
        check("t4_set",    32'(cfg_set_o), 32'd1);
        tick();

        // Timeout: cfg_set rises 8 cycles after req rises.
        start_op(2'd1);
        repeat (TO - 1) tick();
        check("t5_set_early", 32'(cfg_set_o), 32'd0);
        check("t5_req_still", 32'(kmac_if.kmac_req_o), 32'd1);
        tick();
        check("t5_set",    32'(cfg_set_o), 32'd1);
        check("t5_status", 32'(status_o), 32'd3);
        check("t5_errto",  32'(err_timeout_o), 32'd1);
        check("t5_req_lo", 32'(kmac_if.kmac_req_o), 32'd0);
        tick();

        // Start held high while busy: one clr and one set only.
        clr0 = n_clr;
        set0 = n_set;
        start_i = 1'b1;
        op_i    = 2'd2;
        tick();
        repeat (3) tick();
        start_i = 1'b0;
        done_pulse(1'b0);
        tick();
        check("t6_clr_cnt", n_clr - clr0, 32'd1);
        check("t6_set_cnt", n_set - set0, 32'd1);
        check("t6_status",  32'(status_o), 32'd2);

        // Disable mid-operation.
        set0 = n_set;
        start_op(2'd2);
        tick();
        en_i = 1'b0;
        tick();
        check("dis_req",    32'(kmac_if.kmac_req_o), 32'd0);
        check("dis_busy",   32'(busy_o), 32'd0);
        check("dis_status", 32'(status_o), 32'd3);
        check("dis_err",    32'(err_disabled_o), 32'd1);
        check("dis_set",    32'(cfg_set_o), 32'd0);
        en_i    = 1'b1;
        clr0    = n_clr;
        start_i = 1'b1;
        #1;
        check("dis_clr", 32'(cfg_clr_o), 32'd0);
        tick();
        start_i = 1'b0;
        done_pulse(1'b0);
        tick();
        check("dis_req2",    32'(kmac_if.kmac_req_o), 32'd0);
        check("dis_status2", 32'(status_o), 32'd3);
        check("dis_clr_cnt", n_clr - clr0, 32'd0);
        check("dis_set_cnt", n_set - set0, 32'd0);

        // Reset clears sticky flags; reset mid-op returns to idle outputs.
        rst_ni = 1'b0;
        #1;
        check("rst2_errs",   32'({err_timeout_o, err_kmac_o, err_disabled_o}), 32'd0);
        check("rst2_status", 32'(status_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("rst2_init", 32'(cfg_init_o), 32'd1);
        tick();
        start_op(2'd1);
        check("rst3_req_pre", 32'(kmac_if.kmac_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rst3_req",    32'(kmac_if.kmac_req_o), 32'd0);
        check("rst3_busy",   32'(busy_o), 32'd0);
        check("rst3_status", 32'(status_o), 32'd0);
        check("rst3_op",     32'(kmac_if.kmac_op_o), 32'd0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/keymgr_op_ctrl.md
Name: keymgr_op_ctrl

Overview:
- Operation-control stage directly upstream of the key manager configuration-enable register.
- Accepts software operation start requests and drives one KMAC request/response transaction at a time, with a timeout.
- Generates the init/set/clear pulses that lock software configuration while an operation is in flight and unlock it on completion.
- Reports busy, status and sticky error flags to the register file.

Parameters:
- TimeoutCycles, 256, cycles to wait in StWait for kmac_done_i before declaring timeout; legal range is at least 2.
- CntW, $clog2(TimeoutCycles), timeout counter width (derived, not overridable).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- en_i  input  1  key manager enable from lifecycle; low means permanent disable until reset
- init_done_i  input  1  prerequisite ready (entropy seeded); level
- start_i  input  1  software start pulse
- op_i  input  2  operation code; sampled only on an accepted start
- kmac_req_o  output  1  KMAC request, held high until done
- kmac_op_o  output  2  latched operation code
- kmac_done_i  input  1  KMAC completion pulse
- kmac_err_i  input  1  KMAC error; qualified by kmac_done_i
- cfg_init_o  output  1  one-cycle init pulse to the cfg-enable register
- cfg_clr_o  output  1  one-cycle clear pulse, combinational on the start cycle
- cfg_set_o  output  1  one-cycle set pulse on completion
- busy_o  output  1  operation in flight
- status_o  output  2  0 IDLE, 1 WIP, 2 DONE_OK, 3 DONE_ERR
- err_timeout_o  output  1  sticky timeout flag
- err_kmac_o  output  1  sticky KMAC error flag
- err_disabled_o  output  1  sticky disable-abort flag

Behaviour:
- Reset values:
  - State is StInit.
  - Every output is 0. status_o is IDLE and kmac_op_o is 0.
- State machine, StInit:
  - When en_i && init_done_i: cfg_init_o=1 for exactly one cycle and the FSM moves to StIdle.
  - start_i is ignored in this state.
- State machine, StIdle:
  - start_i && en_i accepts a start. On that same cycle:
    - cfg_clr_o=1, combinationally, so the downstream register blocks writes in that cycle.
    - op_i is latched into kmac_op_o.
    - The counter is loaded with 0.
    - status_o becomes WIP on the next cycle.
  - The FSM then moves to StWait.
- State machine, StWait:
  - kmac_req_o=1 and busy_o=1. kmac_op_o is stable.
  - The counter increments every cycle without a done.
  - On kmac_done_i:
    - status_o=DONE_OK when !kmac_err_i.
    - status_o=DONE_ERR and err_kmac_o is set when kmac_err_i.
    - cfg_set_o pulses once and the FSM moves to StIdle.
  - Timeout: counter == TimeoutCycles-1 with no done means status_o=DONE_ERR, err_timeout_o set, cfg_set_o pulses, and the FSM moves to StIdle.
  - kmac_req_o drops on the cycle after done or timeout.
- State machine, StDisabled:
  - Entered from any state on the cycle en_i is sampled low. This takes priority over every other transition.
  - Terminal until reset. start_i and kmac_done_i are ignored.
  - kmac_req_o=0, busy_o=0 and cfg_set_o=0. The cfg-enable register forces itself off on disable.
  - If disable occurs in StWait: status_o=DONE_ERR and err_disabled_o is set. Otherwise status_o holds its value.
- Boundary conditions:
  - kmac_done_i and timeout on the same cycle: done wins and no timeout is flagged.
  - start_i while busy or in StDisabled is dropped, with no pulse and no status change.
  - kmac_done_i outside StWait is ignored.
  - Sticky error flags clear only on reset. status_o holds until the next accepted start.
  - cfg_set_o, cfg_clr_o and cfg_init_o are mutually exclusive; the assertion is that at most one is high per cycle.
  - Reset mid-operation returns the block to StInit with all outputs 0.

Decomposition:
- Package keymgr_op_pkg holds:
  - op_status_e: IDLE, WIP, DONE_OK, DONE_ERR.
  - op_state_e: StInit, StIdle, StWait, StDisabled, using a sparse encoding with an explicit default-to-StDisabled.
  - kmac_op_e, the 2-bit operation code.
- Sub-module keymgr_op_timer is the natural split: a saturating counter with clr and en inputs and an expired output at TimeoutCycles-1.

Test Plan:
- Reset, init_done_i=1, en_i=1 -> cfg_init_o high exactly one cycle, then StIdle. A start_i before init_done_i produces no response.
- start_i with op_i=2 -> cfg_clr_o on the same cycle; kmac_req_o=1 and kmac_op_o=2 on the next cycle. kmac_done_i after 5 cycles with err=0 -> cfg_set_o pulse, status_o=2, busy_o=0.
- kmac_done_i with kmac_err_i=1 -> status_o=3 and err_kmac_o=1. A second start succeeds -> status_o=2, with err_kmac_o still 1.
- TimeoutCycles=8, no done -> cfg_set_o 8 cycles after req rises, status_o=3, err_timeout_o=1. A done arriving exactly at counter=7 -> status_o=2 and no timeout.
- en_i drops during StWait -> kmac_req_o=0 next cycle, status_o=3, err_disabled_o=1, no cfg_set_o. Later start_i and kmac_done_i pulses have no effect.
- start_i repeated while busy -> ignored. Only one cfg_clr_o and one cfg_set_o are seen per transaction.
